vend_dispense_scheduler: RTL and testbench
==========================================

VEND_DISPENSE_SCHEDULER -- requirements
Module: vend_dispense_scheduler

Interface
REQ-001 Parameter NUM_PANELS, default 4, sets the number of coin panels sharing one dispenser and one change hopper.
REQ-002 Parameter PRICE, default 25, sets the item price in Rs.
REQ-003 Parameter TIMEOUT_CYC, default 10, sets the maximum number of cycles the block waits for any motor or hopper handshake.
REQ-004 Port clock, input, 1 bit: rising-edge clock.
REQ-005 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port req, input, NUM_PANELS bits: panel i requests service while its credit is valid.
REQ-007 Port credit, input, 6*NUM_PANELS bits: credit in Rs for panel i, held stable while req[i] is high.
REQ-008 Port gnt, output, NUM_PANELS bits: one-hot; panel i is being served.
REQ-009 Port done, output, NUM_PANELS bits: one-cycle pulse when service of panel i completes.
REQ-010 Port motor_start, output, 1 bit: one-cycle dispense pulse.
REQ-011 Port motor_busy, input, 1 bit: the dispenser is running.
REQ-012 Ports hopper_pay10 and hopper_pay5, outputs, 1 bit each: request payout of one Rs10 coin or one Rs5 coin.
REQ-013 Port hopper_ack, input, 1 bit: one-cycle acknowledge that one coin has been paid.
REQ-014 Port fault, output, 1 bit: a handshake has timed out; the block is locked.
REQ-015 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL use the states IDLE, GRANT, VEND_START, VEND_WAIT_HI, VEND_WAIT_LO, CHANGE, DONE and FAULT.
REQ-017 IDLE with any req high SHALL go to GRANT on the next edge, selecting the round-robin winner that starts at the panel after the last one granted.
REQ-018 GRANT SHALL last one cycle, assert gnt[winner], and latch credit[winner] into an internal 6-bit register.
REQ-019 gnt[winner] SHALL stay high from GRANT through DONE inclusive.
REQ-020 If credit >= PRICE, the FSM SHALL go GRANT -> VEND_START and set change = credit - PRICE.
REQ-021 If credit < PRICE, there is no vend: the FSM SHALL go GRANT -> CHANGE and set change = credit, a full refund.
REQ-022 VEND_START SHALL pulse motor_start for exactly one cycle, then go to VEND_WAIT_HI.
REQ-023 VEND_WAIT_HI SHALL wait for motor_busy=1, then go to VEND_WAIT_LO.
REQ-024 VEND_WAIT_LO SHALL wait for motor_busy=0, then go to CHANGE.
REQ-025 CHANGE SHALL pay change greedily: hold hopper_pay10 while the remaining change is >= 10, otherwise hold hopper_pay5 while it is >= 5.
REQ-026 Each hopper_ack SHALL subtract 10 or 5 from the remaining change.
REQ-027 hopper_pay10 and hopper_pay5 SHALL never be high together.
REQ-028 When the remaining change is < 5, the FSM SHALL go to DONE; any remainder below 5 SHALL be discarded.
REQ-029 DONE SHALL pulse done[winner] for one cycle, move the round-robin pointer to the winner, and return to IDLE.
REQ-030 A timeout counter SHALL clear on every state entry and increment in VEND_WAIT_HI, VEND_WAIT_LO and CHANGE.
REQ-031 When the timeout counter reaches TIMEOUT_CYC, the FSM SHALL go to FAULT.
REQ-032 FAULT SHALL assert fault and drop gnt, and the block SHALL leave FAULT only on reset.
REQ-033 A hopper_ack outside CHANGE, and changes to req or credit after GRANT, SHALL be ignored.
REQ-034 req[i] may fall without a grant; a panel with no request SHALL never be granted.

Reset
REQ-035 Reset SHALL have priority over all other inputs, including in mid-service and in FAULT.
REQ-036 Reset SHALL return the FSM to IDLE and clear gnt, done, motor_start, hopper_pay10, hopper_pay5, fault, busy, the change register and the timeout counter.
REQ-037 Reset SHALL set the round-robin pointer so that panel 0 has the highest priority first.

Configuration
REQ-038 Macro VEND_SCHED_AUDIT_EN SHALL control the audit counters.
REQ-039 With VEND_SCHED_AUDIT_EN defined, the block SHALL add output vend_count (16 bits, +1 per motor_start) and output change_paid (16 bits, +5 or +10 per hopper_ack).
REQ-040 Both audit counters SHALL saturate at their maximum value and clear on reset.
REQ-041 With VEND_SCHED_AUDIT_EN undefined, the counters and their ports SHALL be absent, and the behaviour SHALL otherwise be identical.

Structure
REQ-042 Package vend_pkg SHALL hold the FSM state enum, the constants COIN5=5 and COIN10=10, and the default PRICE.
REQ-043 The round-robin arbiter SHALL be the sub-module vend_rr_arbiter, with ports req, advance and the one-hot grant.

Verification
REQ-044 Single panel, credit=25: one motor_start, no hopper pulses, then done[0].
REQ-045 Credit=40 on panel 2: vend, then pay10 and pay5 in that order, then done[2].
REQ-046 Credit=15: no motor_start, then pay10 and pay5 as a refund, then done.
REQ-047 req=4'b1111 held: grants in the order 0,1,2,3,0, one per service.
REQ-048 motor_busy never rises: fault asserts 10 cycles after entering VEND_WAIT_HI; fault holds until reset; after reset, state is IDLE with all outputs 0.
REQ-049 Reset asserted in CHANGE: on the next edge hopper_pay10, hopper_pay5 and gnt are 0; after reset, panel 0 has the highest priority.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense scheduler.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        VEND_START,
        VEND_WAIT_HI,
        VEND_WAIT_LO,
        CHANGE,
        DONE,
        FAULT
    } vend_state_e;

    localparam logic [5:0] COIN5         = 6'd5;
    localparam logic [5:0] COIN10        = 6'd10;
    localparam int         DEFAULT_PRICE = 25;

endpackage

// File: rtl/vend_rr_arbiter.sv
// Round-robin arbiter: the panel after the last winner has the highest priority.
// The pointer moves to the current grant only when advance is pulsed.
module vend_rr_arbiter
    import vend_pkg::*;
#(
    parameter int NUM_PANELS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_PANELS-1:0] req,
    input  logic                  advance,
    output logic [NUM_PANELS-1:0] grant
);

    localparam int PTR_W = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;

    logic [PTR_W-1:0] last_q;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    // Scan from the panel after the last winner, wrapping, and take the first requester.
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_PANELS; k++) begin
            idx = PTR_W'((int'(last_q) + k) % NUM_PANELS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer register; reset value makes panel 0 the first in line.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= PTR_W'(NUM_PANELS - 1);
        end else if (advance && found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one dispenser motor and one change hopper between several coin panels.
// Optional audit counters (vend_count, change_paid) are built when the macro
// VEND_SCHED_AUDIT_EN is defined; the default build omits them.
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int NUM_PANELS  = 4,
    parameter int PRICE       = DEFAULT_PRICE,
    parameter int TIMEOUT_CYC = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_PANELS-1:0]   req,
    input  logic [6*NUM_PANELS-1:0] credit,
    output logic [NUM_PANELS-1:0]   gnt,
    output logic [NUM_PANELS-1:0]   done,
    output logic                    motor_start,
    input  logic                    motor_busy,
    output logic                    hopper_pay10,
    output logic                    hopper_pay5,
    input  logic                    hopper_ack,
    output logic                    fault,
    output logic                    busy
`ifdef VEND_SCHED_AUDIT_EN
   ,output logic [15:0]             vend_count,
    output logic [15:0]             change_paid
`endif
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]       PRICE_C  = 6'(PRICE);

    vend_state_e           state_q, state_d;
    logic [NUM_PANELS-1:0] winner_q;
    logic [5:0]            change_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  tmo_hit;
    logic [NUM_PANELS-1:0] arb_req;
    logic [NUM_PANELS-1:0] arb_grant;
    logic [5:0]            credit_win;
    logic [5:0]            change_init;
    logic [5:0]            coin_val;
    logic                  coin_ack;

    // While idle the arbiter sees the live requests; during service it sees only
    // the held winner, so the DONE-cycle advance moves the pointer onto that winner.
    assign arb_req = (state_q == IDLE) ? req : winner_q;

    vend_rr_arbiter #(
        .NUM_PANELS (NUM_PANELS)
    ) u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .req     (arb_req),
        .advance (state_q == DONE),
        .grant   (arb_grant)
    );

    // The counter holds the cycles already spent in the state; FAULT is taken
    // on the edge where it would reach TIMEOUT_CYC without the awaited event.
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign coin_val = (change_q >= COIN10) ? COIN10 : COIN5;
    assign coin_ack = (state_q == CHANGE) && hopper_ack && (change_q >= COIN5);

    // Winner's credit and the change owed for it (full refund when short of the price).
    always_comb begin
        credit_win = '0;
        for (int i = 0; i < NUM_PANELS; i++) begin
            if (winner_q[i]) begin
                credit_win = credit_win | credit[i*6 +: 6];
            end
        end
        change_init = (credit_win >= PRICE_C) ? (credit_win - PRICE_C) : credit_win;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_d      = state_q;
        gnt          = '0;
        done         = '0;
        motor_start  = 1'b0;
        hopper_pay10 = 1'b0;
        hopper_pay5  = 1'b0;
        fault        = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (|req) state_d = GRANT;
            end
            GRANT: begin
                gnt     = winner_q;
                state_d = (credit_win >= PRICE_C) ? VEND_START : CHANGE;
            end
            VEND_START: begin
                gnt         = winner_q;
                motor_start = 1'b1;
                state_d     = VEND_WAIT_HI;
            end
            VEND_WAIT_HI: begin
                gnt = winner_q;
                if (motor_busy)   state_d = VEND_WAIT_LO;
                else if (tmo_hit) state_d = FAULT;
            end
            VEND_WAIT_LO: begin
                gnt = winner_q;
                if (!motor_busy)  state_d = CHANGE;
                else if (tmo_hit) state_d = FAULT;
            end
            CHANGE: begin
                gnt = winner_q;
                if (change_q >= COIN10)     hopper_pay10 = 1'b1;
                else if (change_q >= COIN5) hopper_pay5  = 1'b1;
                if (change_q < COIN5) state_d = DONE;
                else if (tmo_hit)     state_d = FAULT;
            end
            DONE: begin
                gnt     = winner_q;
                done    = winner_q;
                state_d = IDLE;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: winner latch, change register and handshake timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            winner_q <= '0;
            change_q <= '0;
            tmo_q    <= '0;
        end else begin
            if (state_q == IDLE && |req) begin
                winner_q <= arb_grant;
            end
            if (state_q == GRANT) begin
                change_q <= change_init;
            end else if (coin_ack) begin
                change_q <= change_q - coin_val;
            end
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (state_q inside {VEND_WAIT_HI, VEND_WAIT_LO, CHANGE}) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

`ifdef VEND_SCHED_AUDIT_EN
    logic [16:0] paid_sum;
    assign paid_sum = {1'b0, change_paid} + 17'(coin_val);

    // Audit counters: dispenses and coin value paid, both saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            vend_count  <= '0;
            change_paid <= '0;
        end else begin
            if (motor_start && vend_count != 16'hFFFF) begin
                vend_count <= vend_count + 16'd1;
            end
            if (coin_ack) begin
                change_paid <= paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Self-checking bench for vend_dispense_scheduler: a transaction-level model
// predicts every cycle's outputs; a negedge process compares them.
module tb_vend_dispense_scheduler;

    localparam int N     = 4;
    localparam int CW    = 6 * N;
    localparam int PRICE = 25;
    localparam int TMO   = 10;

    localparam int M_OK      = 0;
    localparam int M_NO_RISE = 1;
    localparam int M_NO_FALL = 2;
    localparam int M_NO_ACK  = 3;
    localparam int M_RST_CHG = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic         motor;
        logic         p10;
        logic         p5;
        logic         fault;
        logic         busy;
    } obs_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [CW-1:0] credit;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          motor_start;
    logic          motor_busy;
    logic          hopper_pay10;
    logic          hopper_pay5;
    logic          hopper_ack;
    logic          fault;
    logic          busy;
`ifdef VEND_SCHED_AUDIT_EN
    logic [15:0]   vend_count;
    logic [15:0]   change_paid;
`endif

    int    vectors    = 0;
    int    miscompares = 0;
    obs_t  exp_o;
    bit    chk_en = 1'b0;
    int    ptr_m  = N - 1;
    int    m_vends = 0;
    int    m_paid  = 0;
    string ev   = "";
    string gseq = "";
    logic [N-1:0] prev_gnt   = '0;
    logic         prev_fault = 1'b0;

    vend_dispense_scheduler #(
        .NUM_PANELS  (N),
        .PRICE       (PRICE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .credit       (credit),
        .gnt          (gnt),
        .done         (done),
        .motor_start  (motor_start),
        .motor_busy   (motor_busy),
        .hopper_pay10 (hopper_pay10),
        .hopper_pay5  (hopper_pay5),
        .hopper_ack   (hopper_ack),
        .fault        (fault),
        .busy         (busy)
`ifdef VEND_SCHED_AUDIT_EN
       ,.vend_count   (vend_count),
        .change_paid  (change_paid)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Every checked cycle: all outputs against the model's expectation.
    always @(negedge clock) begin
        obs_t act;
        if (chk_en) begin
            act = {gnt, done, motor_start, hopper_pay10, hopper_pay5, fault, busy};
            vectors++;
            if (act !== exp_o) begin
                miscompares++;
                $display("FAIL outputs @%0t: gnt=%b done=%b motor=%b p10=%b p5=%b fault=%b busy=%b, want gnt=%b done=%b motor=%b p10=%b p5=%b fault=%b busy=%b",
                         $time, act.gnt, act.done, act.motor, act.p10, act.p5, act.fault, act.busy,
                         exp_o.gnt, exp_o.done, exp_o.motor, exp_o.p10, exp_o.p5, exp_o.fault, exp_o.busy);
            end
        end
    end

    // Event log of observed DUT activity for the literal scenario checks.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && prev_gnt == '0) begin
                ev   = {ev, $sformatf("G%0d", i)};
                gseq = {gseq, $sformatf("%0d", i)};
            end
        end
        if (motor_start)                ev = {ev, "M"};
        if (hopper_pay10 && hopper_ack) ev = {ev, "T"};
        if (hopper_pay5 && hopper_ack)  ev = {ev, "F"};
        for (int i = 0; i < N; i++) begin
            if (done[i]) ev = {ev, $sformatf("D%0d", i)};
        end
        if (fault && !prev_fault)       ev = {ev, "X"};
        prev_gnt   = gnt;
        prev_fault = fault;
    end

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic check_str(input string name, input string act, input string want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got \"%s\", want \"%s\"", name, act, want);
        end
    endtask

    function automatic obs_t mk(input logic [N-1:0] g, input logic [N-1:0] d, input logic m,
                                input logic p10, input logic p5, input logic f, input logic b);
        obs_t o;
        o = '{gnt: g, done: d, motor: m, p10: p10, p5: p5, fault: f, busy: b};
        return o;
    endfunction

    // Round-robin rule: first requester strictly after the last winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        logic [N-1:0] rot;
        for (int k = 1; k <= N; k++) begin
            rot = r >> ((last + k) % N);
            if (rot[0]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic int change_of(input int cr);
        return (cr >= PRICE) ? cr - PRICE : cr;
    endfunction

    // Post the expectation for the current cycle, then move past the next edge.
    task automatic cyc(input obs_t e);
        exp_o  = e;
        chk_en = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic fault_and_reset();
        for (int k = 0; k < 4; k++) begin
            req        = N'($urandom);
            hopper_ack = 1'($urandom);
            motor_busy = 1'($urandom);
            cyc(mk('0, '0, 0, 0, 0, 1, 1));
        end
        reset = 1'b1;
        cyc(mk('0, '0, 0, 0, 0, 1, 1));
        reset = 1'b0; req = '0; hopper_ack = 1'b0; motor_busy = 1'b0;
        ptr_m = N - 1; m_vends = 0; m_paid = 0;
        cyc(mk('0, '0, 0, 0, 0, 0, 0));
    endtask

    // One complete service, from the last idle cycle to DONE (or a fault/reset exit).
    task automatic serve(input logic [N-1:0] r, input int mode, input bit scramble, output int w);
        logic [N-1:0]  g;
        logic [CW-1:0] sh;
        int cr, rem, d;
        logic p10;
        w = rr_pick(r, ptr_m);
        g = N'(1) << w;
        req = r; hopper_ack = 1'b0; motor_busy = 1'b0;
        cyc(mk('0, '0, 0, 0, 0, 0, 0));
        sh = credit >> (6 * w);
        cr = int'(sh[5:0]);
        cyc(mk(g, '0, 0, 0, 0, 0, 1));
        if (scramble) begin
            req    = N'($urandom);
            credit = CW'($urandom);
        end
        if (cr >= PRICE) begin
            cyc(mk(g, '0, 1, 0, 0, 0, 1));
            m_vends++;
            d = (mode == M_NO_RISE) ? TMO : $urandom_range(TMO - 1, 0);
            for (int k = 0; k <= d && k < TMO; k++) begin
                motor_busy = (k == d);
                hopper_ack = 1'($urandom);
                cyc(mk(g, '0, 0, 0, 0, 0, 1));
            end
            if (mode == M_NO_RISE) begin
                fault_and_reset();
                return;
            end
            d = (mode == M_NO_FALL) ? TMO : $urandom_range(TMO - 1, 0);
            for (int k = 0; k <= d && k < TMO; k++) begin
                motor_busy = (k != d);
                hopper_ack = 1'($urandom);
                cyc(mk(g, '0, 0, 0, 0, 0, 1));
            end
            if (mode == M_NO_FALL) begin
                fault_and_reset();
                return;
            end
        end
        hopper_ack = 1'b0; motor_busy = 1'b0;
        rem = change_of(cr);
        while (rem >= 5) begin
            p10 = (rem >= 10);
            if (mode == M_NO_ACK) begin
                for (int k = 0; k < TMO; k++) cyc(mk(g, '0, 0, p10, !p10, 0, 1));
                fault_and_reset();
                return;
            end
            if ($urandom_range(1, 0) == 1) cyc(mk(g, '0, 0, p10, !p10, 0, 1));
            if (mode == M_RST_CHG) begin
                reset = 1'b1;
                cyc(mk(g, '0, 0, p10, !p10, 0, 1));
                reset = 1'b0; req = '0;
                ptr_m = N - 1; m_vends = 0; m_paid = 0;
                cyc(mk('0, '0, 0, 0, 0, 0, 0));
                return;
            end
            hopper_ack = 1'b1;
            cyc(mk(g, '0, 0, p10, !p10, 0, 1));
            hopper_ack = 1'b0;
            m_paid += p10 ? 10 : 5;
            rem    -= p10 ? 10 : 5;
        end
        cyc(mk(g, '0, 0, 0, 0, 0, 1));
        cyc(mk(g, g, 0, 0, 0, 0, 1));
        ptr_m = w;
        if (scramble) req = '0;
    endtask

    initial begin
        int w;
        logic [N-1:0] r;
        reset = 1'b1; req = '0; credit = '0; motor_busy = 1'b0; hopper_ack = 1'b0;
        @(posedge clock);
        #1;
        cyc(mk('0, '0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cyc(mk('0, '0, 0, 0, 0, 0, 0));

        // Hand-computed pins for the model's rules.
        check("change_40", change_of(40), 15);
        check("change_15", change_of(15), 15);
        check("change_25", change_of(25), 0);
        check("rr_1111_after3", rr_pick(4'b1111, 3), 0);
        check("rr_0101_after0", rr_pick(4'b0101, 0), 2);
        check("rr_0001_after2", rr_pick(4'b0001, 2), 0);

        // Exact price on panel 0.
        credit = '0; credit[5:0] = 6'd25; ev = "";
        serve(4'b0001, M_OK, 1'b0, w);
        check_str("exact_price_p0", ev, "G0MD0");

        // Credit 40 on panel 2: vend, then one 10 and one 5.
        credit = '0; credit[17:12] = 6'd40; ev = "";
        serve(4'b0100, M_OK, 1'b0, w);
        check_str("credit40_p2", ev, "G2MTFD2");

        // Credit 15 on panel 1: refund only.
        credit = '0; credit[11:6] = 6'd15; ev = "";
        serve(4'b0010, M_OK, 1'b0, w);
        check_str("refund15_p1", ev, "G1TFD1");

        // Reset while paying change, then panel 0 leads again.
        credit = '0; credit[23:18] = 6'd40; ev = "";
        serve(4'b1000, M_RST_CHG, 1'b0, w);
        check_str("reset_in_change", ev, "G3M");

        // All panels held requesting: strict rotation from panel 0.
        credit = {4{6'd30}}; gseq = "";
        for (int k = 0; k < 5; k++) serve(4'b1111, M_OK, 1'b0, w);
        check_str("rr_order", gseq, "01230");
        req = '0;
        cyc(mk('0, '0, 0, 0, 0, 0, 0));

        // Motor never starts: fault ten cycles into the wait, held until reset.
        credit = {4{6'd30}}; ev = "";
        serve(4'b0001, M_NO_RISE, 1'b0, w);
        check_str("motor_no_rise", ev, "G0MX");

        // Motor never stops, and hopper never acknowledges.
        serve(4'b0100, M_NO_FALL, 1'b1, w);
        credit = {4{6'd40}};
        serve(4'b0010, M_NO_ACK, 1'b1, w);

        // Randomized services with idle gaps.
        for (int t = 0; t < 80; t++) begin
            r = N'($urandom);
            if (r == '0) r = N'(1) << $urandom_range(N - 1, 0);
            credit = CW'($urandom);
            serve(r, M_OK, 1'b1, w);
            repeat ($urandom_range(2, 0)) begin
                req = '0;
                cyc(mk('0, '0, 0, 0, 0, 0, 0));
            end
        end

`ifdef VEND_SCHED_AUDIT_EN
        check("vend_count", int'(vend_count), m_vends);
        check("change_paid", int'(change_paid), m_paid);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
